axi4_lite_slave_read_responder: RTL and testbench

- Parametrised AXI4-Lite slave read-side responder; successor to the bare read-channel signal bundle, adding actual protocol behaviour.
- Accepts AR handshakes into an outstanding-request FIFO and decodes address range and alignment.
- Fetches data over a simple req/ack backend memory port, with a timeout, and returns in-order R beats with OKAY, SLVERR or DECERR.
- Sits between the slave BFM read interface and the register/memory model.

---
 rtl/axi4_lite_slave_read_responder_pkg.sv | 23 ++
 rtl/axi4_lite_slave_read_responder_if.sv | 55 +++++
 rtl/axi4_lite_sync_fifo.sv | 65 ++++++
 rtl/axi4_lite_slave_read_responder.sv | 190 +++++++++++++++++++
 tb/tb_axi4_lite_slave_read_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_slave_read_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_read_responder_pkg
// Brief    : Shared response codes and FSM state encoding for the read responder.
// Revision : 1.0
// ============================================================================
package axi4_lite_slave_read_responder_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_slave_read_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_read_responder_if
// Brief    : AR/R channels plus backend memory port of the read responder.
// Revision : 1.0
// ============================================================================
interface axi4_lite_slave_read_responder_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int COUNT_WIDTH   = 3
);
  logic [ID_WIDTH-1:0]      arid;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     arvalid;
  logic                     arready;

  logic [ID_WIDTH-1:0]      rid;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;

  logic                     mem_req;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [2:0]               mem_prot;
  logic                     mem_ack;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_err;

  logic [COUNT_WIDTH-1:0]   outstanding_count;

  modport slave (
    input  arid, araddr, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rvalid,
    input  rready,
    output mem_req, mem_addr, mem_prot,
    input  mem_ack, mem_rdata, mem_err,
    output outstanding_count
  );

  modport master (
    output arid, araddr, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rvalid,
    output rready,
    input  mem_req, mem_addr, mem_prot,
    output mem_ack, mem_rdata, mem_err,
    input  outstanding_count
  );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_sync_fifo
// Brief    : Registered-storage synchronous FIFO; an entry is visible one cycle after its push.
// Revision : 1.0
// ============================================================================
module axi4_lite_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_push,
  input  wire logic [WIDTH-1:0]       i_push_data,
  input  wire logic                   i_pop,
  output logic      [WIDTH-1:0]       o_pop_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic      [$clog2(DEPTH):0] o_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               w_push_ok;
  logic               w_pop_ok;

  always_comb begin
    w_push_ok = i_push && !o_full;
    w_pop_ok  = i_pop && !o_empty;
    wr_ptr_d  = wr_ptr_q + c_ptr_w'(w_push_ok);
    rd_ptr_d  = rd_ptr_q + c_ptr_w'(w_pop_ok);
    count_d   = count_q + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_pop_data = mem_q[rd_ptr_q];
  assign o_full     = (count_q == c_cnt_w'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign o_count    = count_q;

endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_read_responder
// Brief    : AXI4-Lite read responder: queued AR, address decode, req/ack backend fetch, in-order R.
// Revision : 1.0
// ============================================================================
module axi4_lite_slave_read_responder
  import axi4_lite_slave_read_responder_pkg::*;
#(
  parameter int              ADDRESS_WIDTH  = 32,
  parameter int              DATA_WIDTH     = 32,
  parameter int              ID_WIDTH       = 4,
  parameter int              FIFO_DEPTH     = 4,
  parameter longint unsigned BASE_ADDR      = 0,
  parameter longint unsigned REGION_SIZE    = 4096,
  parameter int              TIMEOUT_CYCLES = 16,
  parameter bit              STRICT_ALIGN   = 1'b1
) (
  input wire logic                        aclk,
  input wire logic                        areset,
  axi4_lite_slave_read_responder_if.slave bus
);

  localparam int c_entry_w = ID_WIDTH + ADDRESS_WIDTH + 3;
  localparam int c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
  localparam int c_tmo_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDRESS_WIDTH:0]   c_base       = (ADDRESS_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDRESS_WIDTH:0]   c_size       = (ADDRESS_WIDTH+1)'(REGION_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] c_align_mask = ADDRESS_WIDTH'(DATA_WIDTH/8 - 1);
  localparam logic [c_tmo_w-1:0]       c_tmo_last   =
      c_tmo_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                   state_q, state_d;
  logic                     arready_q, arready_d;
  logic [ID_WIDTH-1:0]      rid_q, rid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  resp_e                    rresp_q, rresp_d;
  logic                     rvalid_q, rvalid_d;
  logic                     mem_req_q, mem_req_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]               mem_prot_q, mem_prot_d;
  logic [c_tmo_w-1:0]       tmo_cnt_q, tmo_cnt_d;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [c_cnt_w-1:0]       w_count;
  logic [c_cnt_w-1:0]       w_count_next;
  logic [c_entry_w-1:0]     w_entry;
  logic [ID_WIDTH-1:0]      w_e_id;
  logic [ADDRESS_WIDTH-1:0] w_e_addr;
  logic [2:0]               w_e_prot;
  logic [ADDRESS_WIDTH:0]   w_offset;
  logic                     w_in_range;
  logic                     w_misaligned;
  logic                     w_tmo_hit;

  assign w_push = bus.arvalid && arready_q && !w_full;

  axi4_lite_sync_fifo #(
    .WIDTH (c_entry_w),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk         (aclk),
    .rst         (areset),
    .i_push      (w_push),
    .i_push_data ({bus.arid, bus.araddr, bus.arprot}),
    .i_pop       (w_pop),
    .o_pop_data  (w_entry),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign {w_e_id, w_e_addr, w_e_prot} = w_entry;

  // One extra bit: an address below the base wraps above 2^ADDRESS_WIDTH and fails the size test.
  assign w_offset     = {1'b0, w_e_addr} - c_base;
  assign w_in_range   = (w_offset < c_size);
  assign w_misaligned = ((w_e_addr & c_align_mask) != '0);
  assign w_tmo_hit    = (TIMEOUT_CYCLES > 0) && (tmo_cnt_q == c_tmo_last);

  always_comb begin
    state_d      = state_q;
    rid_d        = rid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rvalid_d     = rvalid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_prot_d   = mem_prot_q;
    tmo_cnt_d    = tmo_cnt_q;
    w_pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          rid_d      = w_e_id;
          mem_addr_d = w_offset[ADDRESS_WIDTH-1:0];
          mem_prot_d = w_e_prot;
          tmo_cnt_d  = '0;
          if (!w_in_range) begin
            rresp_d  = RESP_DECERR;
            rdata_d  = '0;
            rvalid_d = 1'b1;
            state_d  = ST_RESP;
          end else if (STRICT_ALIGN && w_misaligned) begin
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
            rvalid_d = 1'b1;
            state_d  = ST_RESP;
          end else begin
            mem_req_d = 1'b1;
            state_d   = ST_MEM_WAIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ack) begin
          rdata_d   = bus.mem_rdata;
          rresp_d   = bus.mem_err ? RESP_SLVERR : RESP_OKAY;
          mem_req_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = ST_RESP;
        end else if (w_tmo_hit) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          mem_req_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + c_tmo_w'(1);
        end
      end
      ST_RESP: begin
        if (bus.rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // arready is a flop, so it must reflect the occupancy after this edge.
    w_count_next = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    arready_d    = (w_count_next != c_cnt_w'(FIFO_DEPTH));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      arready_q  <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_prot_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rvalid_q   <= rvalid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_prot_q <= mem_prot_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign bus.arready           = arready_q;
  assign bus.rid               = rid_q;
  assign bus.rdata             = rdata_q;
  assign bus.rresp             = rresp_q;
  assign bus.rvalid            = rvalid_q;
  assign bus.mem_req           = mem_req_q;
  assign bus.mem_addr          = mem_addr_q;
  assign bus.mem_prot          = mem_prot_q;
  assign bus.outstanding_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_slave_read_responder
// Brief    : Scoreboard bench for the AXI4-Lite read responder with a scripted backend.
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_slave_read_responder;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axi4_lite_slave_read_responder_if #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .ID_WIDTH      (4),
    .COUNT_WIDTH   (3)
  ) bus ();

  axi4_lite_slave_read_responder #(
    .ADDRESS_WIDTH  (32),
    .DATA_WIDTH     (32),
    .ID_WIDTH       (4),
    .FIFO_DEPTH     (4),
    .BASE_ADDR      (0),
    .REGION_SIZE    (4096),
    .TIMEOUT_CYCLES (16),
    .STRICT_ALIGN   (1'b1)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          beats_seen = 0;
  int          req_cycles = 0;
  int          be_mode = 0;        // 0: ack immediately, 1: never ack
  logic        late_pulse = 1'b0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] burst_addr [6] = '{32'h100, 32'h20, 32'hFFC, 32'h104, 32'h108, 32'h10C};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'h5A5A0000 ^ a);
  endfunction

  function automatic exp_t model(input logic [3:0] id, input logic [31:0] a);
    exp_t e;
    e.id = id;
    if ({1'b0, a} >= 33'd4096) begin
      e.resp = 2'd3;
      e.data = 32'h0;
    end else if (a[1:0] != 2'b00) begin
      e.resp = 2'd2;
      e.data = 32'h0;
    end else if (be_mode == 1) begin
      e.resp = 2'd2;
      e.data = 32'h0;
    end else begin
      e.resp = (a == 32'h20) ? 2'd2 : 2'd0;
      e.data = data_of(a);
    end
    return e;
  endfunction

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr);
    bit done = 0;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arprot  = 3'b010;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      if (bus.arready === 1'b1) begin
        @(posedge aclk);
        #1;
        sb_q.push_back(model(id, addr));
        done = 1;
      end
    end
    bus.arvalid = 1'b0;
    if (!done) check_eq("ar_accept_timeout", 0, 1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (beats_seen < target && k < budget) begin
      @(posedge aclk);
      k++;
    end
    if (beats_seen < target) check_eq("beat_wait_timeout", beats_seen, target);
    #1;
  endtask

  // Backend: answers from the address, error flagged at 0x20.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_err   = 1'b0;
    forever begin
      @(negedge aclk);
      bus.mem_ack   = ((be_mode == 0) && (bus.mem_req === 1'b1)) || late_pulse;
      bus.mem_rdata = data_of(bus.mem_addr);
      bus.mem_err   = (bus.mem_addr == 32'h20);
    end
  end

  // R monitor: every completed beat is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge aclk);
      if (bus.mem_req === 1'b1) req_cycles++;
      if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
        beats_seen++;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("rid", bus.rid, mon_e.id);
          check_eq("rdata", bus.rdata, mon_e.data);
          check_eq("rresp", bus.rresp, mon_e.resp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset      = 1'b1;
    bus.arvalid = 1'b0;
    bus.arid    = '0;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.rready  = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check_eq("rst_arready", bus.arready, 0);
    check_eq("rst_rvalid", bus.rvalid, 0);
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_count", bus.outstanding_count, 0);
    check_eq("rst_rdata", bus.rdata, 0);
    check_eq("rst_rid", bus.rid, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check_eq("arready_after_reset", bus.arready, 1);

    // Single read with minimum latency
    req_cycles = 0;
    send_ar(4'd5, 32'h10);
    @(posedge aclk);
    #1;
    check_eq("t1_mem_req", bus.mem_req, 1);
    check_eq("t1_mem_addr", bus.mem_addr, 32'h10);
    check_eq("t1_mem_prot", bus.mem_prot, 3'b010);
    check_eq("t1_rvalid_early", bus.rvalid, 0);
    @(posedge aclk);
    #1;
    check_eq("t1_rvalid", bus.rvalid, 1);
    wait_beats(1, 20);
    check_eq("t1_req_cycles", req_cycles, 1);

    // Out of range, misaligned, backend error
    req_cycles = 0;
    send_ar(4'd1, 32'h1000);
    wait_beats(2, 20);
    send_ar(4'd2, 32'h2);
    wait_beats(3, 20);
    check_eq("decode_err_no_mem_req", req_cycles, 0);
    send_ar(4'd3, 32'h20);
    wait_beats(4, 20);

    // Backpressure: five accepted, sixth waits for the first R handshake
    bus.rready = 1'b0;
    for (int i = 0; i < 5; i++) send_ar(4'(i), burst_addr[i]);
    @(negedge aclk);
    check_eq("bp_arready", bus.arready, 0);
    check_eq("bp_count", bus.outstanding_count, 4);
    check_eq("bp_no_beats", beats_seen, 4);
    fork
      send_ar(4'd5, burst_addr[5]);
      begin
        repeat (3) @(posedge aclk);
        #1;
        bus.rready = 1'b1;
      end
    join
    check_eq("bp_sixth_after_beat", (beats_seen >= 5) ? 1 : 0, 1);
    wait_beats(10, 100);

    // Timeout followed by a late ack
    be_mode    = 1;
    req_cycles = 0;
    send_ar(4'd6, 32'h40);
    wait_beats(11, 60);
    check_eq("tmo_req_cycles", req_cycles, 16);
    @(posedge aclk);
    #1;
    late_pulse = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    late_pulse = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    check_eq("late_ack_no_beat", beats_seen, 11);
    check_eq("late_ack_mem_req", bus.mem_req, 0);

    // Reset while one request waits on the backend and two are queued
    send_ar(4'd7, 32'h50);
    send_ar(4'd8, 32'h54);
    send_ar(4'd9, 32'h58);
    @(negedge aclk);
    check_eq("pre_rst_count", bus.outstanding_count, 2);
    check_eq("pre_rst_mem_req", bus.mem_req, 1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    sb_q.delete();
    check_eq("mid_rst_mem_req", bus.mem_req, 0);
    check_eq("mid_rst_rvalid", bus.rvalid, 0);
    check_eq("mid_rst_count", bus.outstanding_count, 0);
    be_mode = 0;
    repeat (30) @(posedge aclk);
    #1;
    check_eq("dropped_no_beat", beats_seen, 11);
    send_ar(4'd10, 32'h80);
    wait_beats(12, 20);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
